// File: rtl/my_ram_512_ctrl_pkg.sv
// my_ram_512_ctrl_pkg: shared state encoding and RAM geometry for the RAM request sequencer
package my_ram_512_ctrl_pkg;
    localparam int RAM_ADDR_W = 9;
    localparam int RAM_DATA_W = 16;
    localparam int RAM_DEPTH  = 512;
    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } state_t;
endpackage

// File: rtl/my_ram_512_ctrl.sv
// my_ram_512_ctrl: valid/ready request sequencer and zero-fill engine in front of a 512x16 RAM
module my_ram_512_ctrl
    import my_ram_512_ctrl_pkg::*;
#(
    parameter int ADDR_W         = RAM_ADDR_W,
    parameter int DATA_W         = RAM_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              clear_start,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);
    localparam state_t      ST_RST  = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state, w_state;
    logic [ADDR_W:0]   r_cnt, w_cnt;
    logic              r_req_ready, w_req_ready;
    logic              r_busy, w_busy;
    logic              r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data, w_rsp_data;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
    logic [DATA_W-1:0] r_ram_in, w_ram_in;
    logic              r_ram_load, w_ram_load;
    logic              w_hs;

    assign w_hs      = req_valid && r_req_ready;
    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign ram_addr  = r_ram_addr;
    assign ram_in    = r_ram_in;
    assign ram_load  = r_ram_load;

    // Next-state and next-output decode; every register holds unless its state updates it
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_req_ready = r_req_ready;
        w_busy      = r_busy;
        w_rsp_valid = r_rsp_valid;
        w_rsp_data  = r_rsp_data;
        w_ram_addr  = r_ram_addr;
        w_ram_in    = r_ram_in;
        w_ram_load  = r_ram_load;
        case (r_state)
            ST_CLEAR: begin
                // The counter's top bit marks that the last address has already been issued
                if (r_cnt[ADDR_W]) begin
                    w_ram_load  = 1'b0;
                    w_busy      = 1'b0;
                    w_req_ready = 1'b1;
                    w_state     = ST_IDLE;
                end else begin
                    w_ram_addr = r_cnt[ADDR_W-1:0];
                    w_ram_in   = '0;
                    w_ram_load = 1'b1;
                    w_cnt      = r_cnt + CNT_ONE;
                end
            end
            ST_IDLE: begin
                // A request on the same edge as clear_start wins; the clear is dropped
                if (w_hs) begin
                    w_ram_addr  = req_addr;
                    w_req_ready = 1'b0;
                    if (req_write) begin
                        w_ram_in   = req_data;
                        w_ram_load = 1'b1;
                        w_state    = ST_WRITE;
                    end else begin
                        w_state = ST_READ;
                    end
                end else if (clear_start) begin
                    w_cnt       = '0;
                    w_busy      = 1'b1;
                    w_req_ready = 1'b0;
                    w_state     = ST_CLEAR;
                end
            end
            ST_WRITE: begin
                w_ram_load  = 1'b0;
                w_req_ready = 1'b1;
                w_state     = ST_IDLE;
            end
            ST_READ: begin
                w_rsp_data  = ram_out;
                w_rsp_valid = 1'b1;
                w_state     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                    w_state     = ST_IDLE;
                end
            end
            default: begin
                w_ram_load  = 1'b0;
                w_busy      = 1'b0;
                w_rsp_valid = 1'b0;
                w_req_ready = 1'b1;
                w_state     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any partial clear or pending response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_req_ready <= !CLEAR_ON_RESET;
            r_busy      <= CLEAR_ON_RESET;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_ram_addr  <= '0;
            r_ram_in    <= '0;
            r_ram_load  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_req_ready <= w_req_ready;
            r_busy      <= w_busy;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_ram_addr  <= w_ram_addr;
            r_ram_in    <= w_ram_in;
            r_ram_load  <= w_ram_load;
        end
    end
endmodule
